// File: rtl/sqmux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// sqmux_sel_ctrl
//
// Sequencer for the SELECT pin of an SQMUX clock mux (0 = QMUXIN, 1 = SQHSCK).
// A four-phase REQ/ACK request asks for a source. When the requested source
// differs from the current one, the block:
//   1. drops CLK_EN and holds it low for GATE_CYCLES edges,
//   2. flips SELECT,
//   3. waits SETTLE_CYCLES edges,
//   4. raises CLK_EN again and acknowledges.
// A request for the source that is already selected is acknowledged at once.
// Every output comes from a register, so there is no combinational path from
// any input to any output.
//
// Optional build macro:
//   SQMUX_SEL_SWCNT_EN - adds the SW_COUNT port. It is an 8-bit saturating
//                        count of real SELECT changes, cleared only by reset.
//
// Parameters:
//   GATE_CYCLES   - edges with CLK_EN low before SELECT changes (1..2**CNT_W)
//   SETTLE_CYCLES - edges after the SELECT change before CLK_EN returns high
//                   (1..2**CNT_W)
//   CNT_W         - width of the internal down-counter
//
// Ports:
//   QCK      in   reference clock; all state changes on its rising edge
//   QRTN     in   asynchronous active-low reset
//   REQ      in   level request (four-phase handshake)
//   REQ_SEL  in   requested source; sampled only when a request is accepted
//   ACK      out  request complete; stays high until REQ goes low
//   BUSY     out  high while a source change is in progress
//   SELECT   out  registered SQMUX SELECT
//   CLK_EN   out  downstream clock-use enable; low while switching
//   SW_COUNT out  [7:0] switch count (only with SQMUX_SEL_SWCNT_EN)
// -----------------------------------------------------------------------------
module sqmux_sel_ctrl #(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic       QCK,
  input  logic       QRTN,
  input  logic       REQ,
  input  logic       REQ_SEL,
  output logic       ACK,
  output logic       BUSY,
  output logic       SELECT,
  output logic       CLK_EN
`ifdef SQMUX_SEL_SWCNT_EN
  ,
  output logic [7:0] SW_COUNT
`endif
);

  // Both windows are loaded as (cycles - 1). The counter therefore has to
  // represent values up to 2**CNT_W - 1, which sets the legal range.
  if (GATE_CYCLES < 1 || GATE_CYCLES > (2 ** CNT_W)) begin : g_bad_gate
    $error("sqmux_sel_ctrl: GATE_CYCLES out of range 1..2**CNT_W");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > (2 ** CNT_W)) begin : g_bad_settle
    $error("sqmux_sel_ctrl: SETTLE_CYCLES out of range 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SETTLE = 2'd2,
    ACKW   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             target_q, target_d;
  logic             ack_d, busy_d, select_d, clk_en_d;

  // State and output registers.
  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= 1'b0;
      ACK      <= 1'b0;
      BUSY     <= 1'b0;
      SELECT   <= 1'b0;
      CLK_EN   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      ACK      <= ack_d;
      BUSY     <= busy_d;
      SELECT   <= select_d;
      CLK_EN   <= clk_en_d;
    end
  end

  // Next-state logic. Each output keeps its value unless a transition
  // changes it. This keeps the "untouched" outputs of a same-source request
  // exactly as they were.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    ack_d    = ACK;
    busy_d   = BUSY;
    select_d = SELECT;
    clk_en_d = CLK_EN;

    case (state_q)
      IDLE: begin
        if (REQ && !ACK) begin
          target_d = REQ_SEL;
          if (REQ_SEL == SELECT) begin
            ack_d   = 1'b1;
            state_d = ACKW;
          end else begin
            clk_en_d = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = GATE_LOAD;
            state_d  = GATE;
          end
        end
      end

      GATE: begin
        if (cnt_q == '0) begin
          select_d = target_q;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          ack_d    = 1'b1;
          state_d  = ACKW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ACKW: begin
        // If REQ was already dropped during the switch, this releases ACK
        // after a single cycle.
        if (!REQ) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SQMUX_SEL_SWCNT_EN
  // Counts only edges where SELECT really changes. Same-source requests
  // never touch SELECT, so they are not counted.
  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      SW_COUNT <= 8'd0;
    end else if ((select_d != SELECT) && (SW_COUNT != 8'hFF)) begin
      SW_COUNT <= SW_COUNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sqmux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqmux_sel_ctrl
//
// Self-checking bench for sqmux_sel_ctrl at its default parameters. Each
// driven cycle queues the expected {SELECT, CLK_EN, BUSY, ACK} vector, taken
// from the documented timeline measured from the acceptance edge. The vector
// is popped and compared one time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_sqmux_sel_ctrl;

  localparam int G = 4;
  localparam int S = 8;

  logic QCK = 1'b0;
  logic QRTN;
  logic REQ;
  logic REQ_SEL;
  logic ACK, BUSY, SELECT, CLK_EN;
`ifdef SQMUX_SEL_SWCNT_EN
  logic [7:0] SW_COUNT;
`endif

  int errors = 0;
  int checks = 0;
  bit cur_sel = 1'b0;

  typedef struct {
    string      tag;
    logic [3:0] v;
  } exp_t;

  exp_t exp_q[$];

  always #5 QCK = ~QCK;

  sqmux_sel_ctrl #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (4)
  ) dut (
    .QCK     (QCK),
    .QRTN    (QRTN),
    .REQ     (REQ),
    .REQ_SEL (REQ_SEL),
    .ACK     (ACK),
    .BUSY    (BUSY),
    .SELECT  (SELECT),
    .CLK_EN  (CLK_EN)
`ifdef SQMUX_SEL_SWCNT_EN
    ,
    .SW_COUNT(SW_COUNT)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic score();
    exp_t x;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = exp_q.pop_front();
      check(x.tag, {28'd0, SELECT, CLK_EN, BUSY, ACK}, {28'd0, x.v});
    end
  endtask

  // Drives one cycle of inputs, queues the outputs expected after the next
  // rising edge, and checks them one time unit after that edge.
  task automatic cyc(input string tag, input bit req, input bit rsel,
                     input logic [3:0] e);
    exp_t x;
    REQ     = req;
    REQ_SEL = rsel;
    x.tag   = tag;
    x.v     = e;
    exp_q.push_back(x);
    @(posedge QCK);
    #1;
    score();
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, {cur_sel, 3'b100});
  endtask

  // One request. REQ is high for edges 0..req_len-1, counted from the
  // acceptance edge. REQ_SEL carries the target until edge glitch_k and its
  // inverse after that. If abort_k >= 0, reset is asserted just before edge
  // abort_k.
  task automatic do_req(input string tag, input bit target, input int req_len,
                        input int glitch_k, input int abort_k);
    bit         sw;
    bit         req;
    bit         rsel;
    bit         fin;
    bit         aborted;
    int         done_k;
    logic [3:0] e;
    exp_t       x;
    sw      = (target != cur_sel);
    done_k  = sw ? (G + S) : 0;
    fin     = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k < 64 && !fin; k++) begin
      if (k == abort_k) begin
        QRTN  = 1'b0;
        x.tag = {tag, "_rst"};
        x.v   = 4'b0100;
        exp_q.push_back(x);
        #1;
        score();
        fin     = 1'b1;
        aborted = 1'b1;
      end else begin
        req  = (k < req_len);
        rsel = (k < glitch_k) ? target : ~target;
        if (k == done_k)     e = {target, 3'b101};
        else if (k > done_k) e = {target, 2'b10, req};
        else if (k < G)      e = {cur_sel, 3'b010};
        else                 e = {target, 3'b010};
        cyc(tag, req, rsel, e);
        if (k > done_k && !req) fin = 1'b1;
      end
    end
    if (!fin) check({tag, "_timeout"}, 32'd0, 32'd1);
    cur_sel = aborted ? 1'b0 : target;
  endtask

  initial begin
    QRTN    = 1'b0;
    REQ     = 1'b1;
    REQ_SEL = 1'b1;
    #3;
    // Reset held with REQ high.
    for (int i = 0; i < 3; i++) cyc("reset_hold", 1'b1, 1'b1, 4'b0100);
`ifdef SQMUX_SEL_SWCNT_EN
    check("swcnt_reset", {24'd0, SW_COUNT}, 32'd0);
`endif
    QRTN = 1'b1;
    idle("reset_quiet", 20);

    do_req("sw01", 1'b1, 16, 99, -1);
    idle("gap1", 2);
    do_req("same1", 1'b1, 3, 99, -1);
    idle("gap2", 2);
    do_req("drop10_glitch", 1'b0, 2, 3, -1);
    idle("gap3", 2);
    do_req("sw01_short", 1'b1, 1, 99, -1);
    idle("gap4", 2);
    do_req("sw10", 1'b0, 13, 99, -1);
    idle("gap5", 2);

    // Reset in the middle of a 0->1 switch, after SELECT has already moved.
    do_req("abort01", 1'b1, 20, 99, 6);
    cyc("abort_hold", 1'b0, 1'b0, 4'b0100);
    QRTN = 1'b1;
    idle("abort_gap", 2);
    do_req("fresh01", 1'b1, 14, 99, -1);
    idle("gap6", 2);

`ifdef SQMUX_SEL_SWCNT_EN
    QRTN = 1'b0;
    cyc("swcnt_clr", 1'b0, 1'b0, 4'b0100);
    cur_sel = 1'b0;
    check("swcnt_clr", {24'd0, SW_COUNT}, 32'd0);
    QRTN = 1'b1;
    idle("swcnt_gap", 1);
    do_req("cnt_a", 1'b1, 1, 99, -1);
    do_req("cnt_same_a", 1'b1, 1, 99, -1);
    do_req("cnt_b", 1'b0, 1, 99, -1);
    do_req("cnt_same_b", 1'b0, 2, 99, -1);
    do_req("cnt_c", 1'b1, 1, 99, -1);
    check("swcnt_three", {24'd0, SW_COUNT}, 32'd3);
    for (int i = 0; i < 300; i++) do_req("cnt_sat", ~cur_sel, 1, 99, -1);
    check("swcnt_saturate", {24'd0, SW_COUNT}, 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sqmux_sel_ctrl.md
Name: sqmux_sel_ctrl

Overview:
- Single-clock sequencer that drives the SELECT pin of an SQMUX clock mux (0 = QMUXIN, 1 = SQHSCK).
- Accepts a four-phase REQ/ACK source-change request and gates downstream clock use via CLK_EN for a quiesce window.
- Flips SELECT, waits a settle window, re-enables, then acknowledges.
- Clocked by an always-running reference clock; sits between the fabric clock-management logic and the SQMUX instance.

Parameters:
- GATE_CYCLES, 4, cycles CLK_EN is low before SELECT changes (range 1..2^CNT_W).
- SETTLE_CYCLES, 8, cycles after SELECT changes before CLK_EN returns high (range 1..2^CNT_W).
- CNT_W, 4, width of the internal down-counter.

Ports:
- QCK  input  1  reference clock; all state updates on its rising edge.
- QRTN  input  1  reset; asynchronous, active-low.
- REQ  input  1  level request, four-phase handshake.
- REQ_SEL  input  1  requested source; sampled only at acceptance.
- ACK  output  1  request complete; held until REQ is low.
- BUSY  output  1  high while a source change is in progress (GATE/SETTLE).
- SELECT  output  1  drives SQMUX SELECT; registered.
- CLK_EN  output  1  downstream clock-use enable; low during switch.
- SW_COUNT  output  8  only when SQMUX_SEL_SWCNT_EN is defined.

Behaviour:
- Reset (QRTN low, asynchronous): state IDLE, SELECT=0, CLK_EN=1, ACK=0, BUSY=0, counter=0, SW_COUNT=0.
  - Reset asserted mid-sequence forces these values immediately.
  - This includes SELECT returning to 0 regardless of the prior source.
- All outputs are registered, with no combinational paths from inputs to outputs.
- "Edge t0" is the acceptance edge; outputs change just after the named edge.
- States: IDLE, GATE, SETTLE, ACKW.
- IDLE:
  - Accepts when REQ=1 and ACK=0; latches REQ_SEL as target.
  - If target==SELECT (same source): ACK=1 at t0, go to ACKW; CLK_EN, SELECT and BUSY are untouched.
  - If target!=SELECT: CLK_EN=0, BUSY=1 at t0, counter=GATE_CYCLES-1, go to GATE.
- GATE:
  - Counter decrements each edge.
  - At the edge where counter==0: SELECT=target, counter=SETTLE_CYCLES-1, go to SETTLE.
  - SELECT therefore changes at edge t0+GATE_CYCLES.
- SETTLE:
  - Counter decrements each edge.
  - At counter==0: CLK_EN=1, BUSY=0, ACK=1, go to ACKW.
  - This happens at edge t0+GATE_CYCLES+SETTLE_CYCLES.
- ACKW:
  - While REQ=1, hold ACK=1.
  - At the first edge with REQ=0: ACK=0, go to IDLE.
  - A new request is accepted no earlier than the edge after ACK falls.
- REQ may drop during GATE/SETTLE:
  - The sequence still completes.
  - ACK is then high for exactly one cycle, since REQ is already low in ACKW.
- REQ_SEL changes after acceptance are ignored until the next acceptance.
- SELECT never changes while CLK_EN=1.
- CLK_EN is never high in GATE or SETTLE.
- Counter arithmetic is unsigned CNT_W bits with no wrap; it is loaded before use. Parameter ranges above are enforced by elaboration-time checks.

Optional Feature:
- Macro: SQMUX_SEL_SWCNT_EN.
- Defined:
  - 8-bit SW_COUNT port increments by 1 on each edge where SELECT actually changes.
  - Saturates at 255.
  - Cleared only by reset.
  - Same-source requests do not count.
- Undefined: no SW_COUNT port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset: drive QRTN=0 with REQ=1 -> SELECT=0, CLK_EN=1, ACK=0, BUSY=0; release reset with REQ=0 -> outputs unchanged for 20 cycles.
- Switch 0->1 at defaults: REQ=1, REQ_SEL=1 accepted at t0 -> CLK_EN=0 and BUSY=1 from t0; SELECT=1 at t0+4; CLK_EN=1, BUSY=0, ACK=1 at t0+12. Drop REQ at t0+15 -> ACK=0 at t0+16.
- Same source: SELECT=1, REQ=1, REQ_SEL=1 -> ACK=1 at t0; CLK_EN stays 1 and BUSY stays 0 throughout.
- Early REQ drop and REQ_SEL glitch: REQ high for 2 cycles with REQ_SEL=0 from SELECT=1, then REQ_SEL toggled to 1 at t0+3 -> SELECT=0 at t0+4; ACK high exactly one cycle at t0+12.
- Reset mid-op: assert QRTN=0 at t0+6 during a 0->1 switch -> SELECT=0, CLK_EN=1, BUSY=0 immediately; a fresh request after release completes normally.
- SQMUX_SEL_SWCNT_EN defined: 3 real switches plus 2 same-source requests -> SW_COUNT=3; 300 real switches -> SW_COUNT=255.
